// File: rtl/hotspot_overlay.sv
// LCD timing generator with N-channel hotspot marker overlay, RGB565 out; all outputs registered (1 cycle after counter state).
// Free-running pixel stream with no backpressure; ena=0 freezes the counters and blanks the outputs.
module hotspot_overlay #(
    parameter int          H_ACTIVE = 480,
    parameter int          H_FP     = 2,
    parameter int          H_SYNC   = 41,
    parameter int          H_BP     = 2,
    parameter int          V_ACTIVE = 272,
    parameter int          V_FP     = 2,
    parameter int          V_SYNC   = 10,
    parameter int          V_BP     = 2,
    parameter int          N_SPOT   = 4,
    parameter int          RADIUS   = 4,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic                  clk_pix,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [16*N_SPOT-1:0]  spot_x_in,
    input  logic [16*N_SPOT-1:0]  spot_y_in,
    input  logic [N_SPOT-1:0]     spot_valid,
    input  logic [16*N_SPOT-1:0]  spot_color,
    input  logic [1:0]            mode,
    output logic                  syn_off0_hs,
    output logic                  syn_off0_vs,
    output logic                  out_de,
    output logic                  frame_start,
    output logic [15:0]           thd_rgb_data
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [16:0] RAD    = 17'(RADIUS);

    logic [15:0]       h_cnt;
    logic [15:0]       v_cnt;
    logic [15:0]       sh_x     [N_SPOT];
    logic [15:0]       sh_y     [N_SPOT];
    logic [15:0]       sh_color [N_SPOT];
    logic [N_SPOT-1:0] sh_valid;
    logic [1:0]        sh_mode;

    logic              active;
    logic              hs_n;
    logic              vs_n;
    logic              h_last;
    logic              frame_last;
    logic [15:0]       pix_color;
    logic signed [16:0] dx;
    logic signed [16:0] dy;
    logic [16:0]       adx;
    logic [16:0]       ady;
    logic              in_sq;
    logic              hit;

    always_comb begin
        active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_n       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        h_last     = (h_cnt == H_LAST);
        frame_last = h_last && (v_cnt == V_LAST);
    end

    // Scan from the highest channel down so the lowest-index hit overwrites last.
    always_comb begin
        pix_color = BG_COLOR;
        dx        = '0;
        dy        = '0;
        adx       = '0;
        ady       = '0;
        in_sq     = 1'b0;
        hit       = 1'b0;
        for (int i = N_SPOT - 1; i >= 0; i--) begin
            dx    = $signed({1'b0, h_cnt}) - $signed({1'b0, sh_x[i]});
            dy    = $signed({1'b0, v_cnt}) - $signed({1'b0, sh_y[i]});
            adx   = dx[16] ? $unsigned(-dx) : $unsigned(dx);
            ady   = dy[16] ? $unsigned(-dy) : $unsigned(dy);
            in_sq = (adx <= RAD) && (ady <= RAD);
            case (sh_mode)
                2'd0:    hit = in_sq;
                2'd1:    hit = in_sq && ((adx == RAD) || (ady == RAD));
                2'd2:    hit = ((dx == '0) && (ady <= RAD)) || ((dy == '0) && (adx <= RAD));
                default: hit = 1'b0;
            endcase
            if (sh_valid[i] && hit) begin
                pix_color = sh_color[i];
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            sh_valid     <= '0;
            sh_mode      <= 2'd3;
            syn_off0_hs  <= 1'b1;
            syn_off0_vs  <= 1'b1;
            out_de       <= 1'b0;
            frame_start  <= 1'b0;
            thd_rgb_data <= '0;
        end else if (!ena) begin
            syn_off0_hs  <= 1'b1;
            syn_off0_vs  <= 1'b1;
            out_de       <= 1'b0;
            frame_start  <= 1'b0;
            thd_rgb_data <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 16'd1;
            if (h_last) begin
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 16'd1;
            end
            // Shadow capture on the very last clock of the frame; the next frame renders from these only.
            if (frame_last) begin
                for (int i = 0; i < N_SPOT; i++) begin
                    sh_x[i]     <= spot_x_in[16*i +: 16];
                    sh_y[i]     <= spot_y_in[16*i +: 16];
                    sh_color[i] <= spot_color[16*i +: 16];
                end
                sh_valid <= spot_valid;
                sh_mode  <= mode;
            end
            syn_off0_hs  <= hs_n;
            syn_off0_vs  <= vs_n;
            out_de       <= active;
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
            thd_rgb_data <= active ? pix_color : 16'h0000;
        end
    end
endmodule

// File: tb/tb_hotspot_overlay.sv
// Scoreboarded bench for hotspot_overlay on a small panel geometry with a frame-level reference model.
module tb_hotspot_overlay;
    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 12, VFP = 1, VSW = 2, VBP = 1;
    localparam int N = 4, R = 2;
    localparam logic [15:0] BG = 16'h1234;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    logic            clk_pix = 1'b0;
    logic            rst_n;
    logic            ena;
    logic [16*N-1:0] spot_x_in;
    logic [16*N-1:0] spot_y_in;
    logic [N-1:0]    spot_valid;
    logic [16*N-1:0] spot_color;
    logic [1:0]      mode;
    logic            syn_off0_hs;
    logic            syn_off0_vs;
    logic            out_de;
    logic            frame_start;
    logic [15:0]     thd_rgb_data;

    hotspot_overlay #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .N_SPOT(N), .RADIUS(R), .BG_COLOR(BG)
    ) dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .ena(ena),
        .spot_x_in(spot_x_in), .spot_y_in(spot_y_in), .spot_valid(spot_valid),
        .spot_color(spot_color), .mode(mode),
        .syn_off0_hs(syn_off0_hs), .syn_off0_vs(syn_off0_vs), .out_de(out_de),
        .frame_start(frame_start), .thd_rgb_data(thd_rgb_data)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [15:0] rgb;
    } out_t;

    out_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] col[4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0};
    int          de_cnt;
    int          col_cnt[4];

    // Reference model state: linear position within the frame plus the latched spot set.
    int m_pos;
    int sh_x[N], sh_y[N], sh_c[N];
    bit sh_v[N];
    int sh_mode;

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit spot_hit(int m, int dx, int dy);
        bit sq;
        sq = (iabs(dx) <= R) && (iabs(dy) <= R);
        case (m)
            0: return sq;
            1: return sq && (iabs(dx) == R || iabs(dy) == R);
            2: return (dx == 0 && iabs(dy) <= R) || (dy == 0 && iabs(dx) <= R);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] model_pixel(int x, int y);
        for (int i = 0; i < N; i++)
            if (sh_v[i] && spot_hit(sh_mode, x - sh_x[i], y - sh_y[i])) return 16'(sh_c[i]);
        return BG;
    endfunction

    // Compute what the DUT must show after the coming clock edge, then advance one cycle.
    task automatic tick();
        out_t e;
        int   x, y;
        bit   act;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0; e.rgb = 16'h0000;
        if (!rst_n) begin
            m_pos   = 0;
            sh_mode = 3;
            for (int i = 0; i < N; i++) sh_v[i] = 1'b0;
        end else if (ena) begin
            x    = m_pos % HT;
            y    = m_pos / HT;
            act  = (x < HA) && (y < VA);
            e.hs = !(x >= HA + HFP && x < HA + HFP + HSW);
            e.vs = !(y >= VA + VFP && y < VA + VFP + VSW);
            e.de = act;
            e.fs = (m_pos == 0);
            e.rgb = act ? model_pixel(x, y) : 16'h0000;
            if (m_pos == FRAME - 1) begin
                for (int i = 0; i < N; i++) begin
                    sh_x[i] = int'(spot_x_in[16*i +: 16]);
                    sh_y[i] = int'(spot_y_in[16*i +: 16]);
                    sh_c[i] = int'(spot_color[16*i +: 16]);
                    sh_v[i] = spot_valid[i];
                end
                sh_mode = int'(mode);
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(e);
        @(negedge clk_pix);
    endtask

    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clk_pix);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.hs = syn_off0_hs; a.vs = syn_off0_vs; a.de = out_de;
                a.fs = frame_start; a.rgb = thd_rgb_data;
                tests++;
                if (a !== e) begin
                    fails++;
                    if (fails <= 20)
                        $display("FAIL pixel cyc=%0d got hs=%b vs=%b de=%b fs=%b rgb=%h want hs=%b vs=%b de=%b fs=%b rgb=%h",
                                 cyc, a.hs, a.vs, a.de, a.fs, a.rgb, e.hs, e.vs, e.de, e.fs, e.rgb);
                end
                if (out_de === 1'b1) begin
                    de_cnt++;
                    for (int c = 0; c < 4; c++)
                        if (thd_rgb_data === col[c]) col_cnt[c]++;
                end
            end
        end
    end

    task automatic check(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_spot(int i, int x, int y, int c, bit v);
        spot_x_in[16*i +: 16]  = 16'(x);
        spot_y_in[16*i +: 16]  = 16'(y);
        spot_color[16*i +: 16] = 16'(c);
        spot_valid[i]          = v;
    endtask

    task automatic clear_spots();
        for (int i = 0; i < N; i++) set_spot(i, 0, 0, 0, 1'b0);
    endtask

    task automatic sync_frame();
        tick();
        while (m_pos != 0) tick();
    endtask

    task automatic measure(int drop_at, int drop_len);
        de_cnt = 0;
        for (int c = 0; c < 4; c++) col_cnt[c] = 0;
        for (int k = 0; k < FRAME + drop_len; k++) begin
            ena = !(k >= drop_at && k < drop_at + drop_len);
            tick();
        end
        ena = 1'b1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            spot_x_in[16*i +: 16]  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, HA + 3));
            spot_y_in[16*i +: 16]  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, VA + 3));
            spot_color[16*i +: 16] = ($urandom_range(0, 1) == 0) ? col[i] : 16'($urandom);
        end
        spot_valid = 4'($urandom);
        mode       = 2'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        mode  = 2'd0;
        for (int i = 0; i < N; i++) set_spot(i, 3 + 3 * i, 4, int'(col[i]), 1'b1);
        @(negedge clk_pix);

        // Reset, then the first frame must be background only despite all spots valid.
        repeat (3) tick();
        rst_n = 1'b1;
        measure(0, 0);
        check("first_frame_de", de_cnt, HA * VA);
        for (int c = 0; c < 4; c++) check($sformatf("first_frame_col%0d", c), col_cnt[c], 0);

        // Mid-frame reset aborts the frame; the next frame is again background only.
        repeat (100) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        measure(0, 0);
        check("post_reset_col0", col_cnt[0], 0);

        // Single marker in the three shapes.
        clear_spots();
        set_spot(0, 7, 6, int'(col[0]), 1'b1);
        mode = 2'd0; sync_frame(); measure(0, 0); check("square_px", col_cnt[0], 25);
        mode = 2'd1; sync_frame(); measure(0, 0); check("box_px", col_cnt[0], 16);
        mode = 2'd2; sync_frame(); measure(0, 0); check("cross_px", col_cnt[0], 9);
        mode = 2'd3; sync_frame(); measure(0, 0); check("off_px", col_cnt[0], 0);

        // Priority on overlap plus clipping at both corners.
        mode = 2'd0;
        set_spot(0, 5, 5, int'(col[0]), 1'b1);
        set_spot(1, 7, 5, int'(col[1]), 1'b1);
        set_spot(2, 0, 0, int'(col[2]), 1'b1);
        set_spot(3, HA + 1, VA + 1, int'(col[3]), 1'b1);
        sync_frame(); measure(0, 0);
        check("prio_ch0", col_cnt[0], 25);
        check("prio_ch1", col_cnt[1], 10);
        check("clip_origin", col_cnt[2], 9);
        check("clip_far", col_cnt[3], 1);

        // Coordinate change mid-frame only takes effect from the following frame.
        clear_spots();
        set_spot(0, 7, 6, int'(col[0]), 1'b1);
        sync_frame();
        while (m_pos < 5 * HT) tick();
        set_spot(0, 12, 6, int'(col[0]), 1'b1);
        sync_frame(); measure(0, 0);
        check("moved_px", col_cnt[0], 25);

        // Enable dropped mid-line: the frame still delivers every active pixel.
        measure(5 * HT + 4, 50);
        check("gated_de", de_cnt, HA * VA);
        check("gated_col0", col_cnt[0], 25);

        // Randomized traffic with occasional enable drops and resets.
        for (int k = 0; k < FRAME * 15; k++) begin
            if ($urandom_range(0, 149) == 0) rand_inputs();
            ena   = ($urandom_range(0, 19) != 0);
            rst_n = ($urandom_range(0, 2999) != 0);
            tick();
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (4) tick();
        @(posedge clk_pix);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
